// File: rtl/lcd_scanout.sv
// lcd_scanout: frame-buffer reader. Scans WIDTH x HEIGHT pixels in row-major
// order after frame_start and streams them over valid/ready. A 2-entry skid
// buffer hides the 1-cycle read latency and downstream backpressure.
module lcd_scanout #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 144,
    parameter int SHADE_BITS = 2,
    parameter int ADDR_BITS  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  fb_rd_en,
    output logic [ADDR_BITS-1:0]  fb_addr,
    input  logic [SHADE_BITS-1:0] fb_rdata,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [SHADE_BITS-1:0] pix_data,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0]        X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]        Y_LAST = YW'(HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] A_LAST = ADDR_BITS'(WIDTH * HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_inflight;
    logic [SHADE_BITS-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic [XW-1:0]         r_out_x;
    logic [YW-1:0]         r_out_y;
    logic                  r_done;
    logic                  r_overrun;

    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_rd;
    logic                  w_last_rd;
    logic                  w_last_acc;

    // Read issue: only while the buffer plus the in-flight read still has room after this cycle's pop
    always_comb begin
        w_pop      = (r_count != 2'd0) && pix_ready;
        w_level    = {1'b0, r_count} + 3'(r_inflight) - 3'(w_pop);
        w_rd       = (r_state == S_SCAN) && (w_level < 3'd2);
        w_last_rd  = w_rd && (r_addr == A_LAST);
        w_last_acc = w_pop && (r_out_x == X_LAST) && (r_out_y == Y_LAST);
    end

    // Frame state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (frame_start) r_state <= S_SCAN;
                S_SCAN:  if (w_last_rd)   r_state <= S_DRAIN;
                S_DRAIN: if (w_last_acc)  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read address and in-flight tracking; address returns to 0 after the last read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if (w_rd) r_addr <= w_last_rd ? '0 : r_addr + ADDR_BITS'(1);
        end
    end

    // Two-entry skid buffer: push returning read data, pop on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wptr] <= fb_rdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

    // Output position counters; the head entry is always the pixel at (x, y)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_x <= '0;
            r_out_y <= '0;
        end else if (w_pop) begin
            if (r_out_x == X_LAST) begin
                r_out_x <= '0;
                r_out_y <= (r_out_y == Y_LAST) ? '0 : r_out_y + YW'(1);
            end else begin
                r_out_x <= r_out_x + XW'(1);
            end
        end
    end

    // Status pulses: frame completion and frame_start while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_last_acc;
            r_overrun <= frame_start && (r_state != S_IDLE);
        end
    end

    assign fb_rd_en   = w_rd;
    assign fb_addr    = r_addr;
    assign pix_valid  = (r_count != 2'd0);
    assign pix_data   = pix_valid ? r_mem[r_rptr] : '0;
    assign pix_sof    = pix_valid && (r_out_x == '0) && (r_out_y == '0);
    assign pix_eol    = pix_valid && (r_out_x == X_LAST);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;
    assign overrun    = r_overrun;

endmodule
